uart_ssd_multidigit: RTL and testbench

Parametrised N-digit hex display controller for the multiplexed seven-segment display.
- Accepts received-byte strobes from the UART receiver and keeps a shift buffer of the last NUM_DIGITS/2 bytes.
- Scans the digits at a prescaled refresh rate and drives the shared segment bus through Segment_Selector.
- Digits with no byte received yet show a dash.

---
 rtl/ssd_pkg.sv | 32 +++
 rtl/Segment_Selector.sv | 37 +++
 rtl/ssd_refresh_tick.sv | 30 +++
 rtl/uart_ssd_multidigit.sv | 139 +++++++++++++
 tb/tb_uart_ssd_multidigit.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment display blocks.
//   SSD_SEG_W               segment bus width
//   BYTE_W                  received byte width
//   SSD_DEFAULT_REFRESH_DIV clk cycles per digit slot (50 MHz / (60 Hz x 4 digits))
//   ssd_clog2()             ceil(log2(n))
//   ssd_idx_w()             counter/index width for n states, never below 1
package ssd_pkg;

   localparam int unsigned SSD_SEG_W               = 7;
   localparam int unsigned BYTE_W                  = 8;
   localparam int unsigned SSD_DEFAULT_REFRESH_DIV = 208_333;

   typedef logic [BYTE_W-1:0] ssd_byte_t;

   function automatic int unsigned ssd_clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = (n > 0) ? n - 1 : 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Width needed to hold values 0..n-1 (at least one bit).
   function automatic int unsigned ssd_idx_w(input int unsigned n);
      return (n > 1) ? ssd_clog2(n) : 1;
   endfunction

endpackage

// File: rtl/Segment_Selector.sv
// Hex nibble to seven-segment decoder (active-high, bit order gfedcba).
//   nibble    hex value to show
//   dash      show a dash (segment g only); nibble is ignored
//   segments  segment drive
module Segment_Selector
   import ssd_pkg::*;
(
   input  logic [3:0]           nibble,
   input  logic                 dash,
   output logic [SSD_SEG_W-1:0] segments
);

   always_comb begin
      segments = 7'h40;
      if (!dash) begin
         case (nibble)
            4'h0: segments = 7'h3F;
            4'h1: segments = 7'h06;
            4'h2: segments = 7'h5B;
            4'h3: segments = 7'h4F;
            4'h4: segments = 7'h66;
            4'h5: segments = 7'h6D;
            4'h6: segments = 7'h7D;
            4'h7: segments = 7'h07;
            4'h8: segments = 7'h7F;
            4'h9: segments = 7'h6F;
            4'hA: segments = 7'h77;
            4'hB: segments = 7'h7C;
            4'hC: segments = 7'h39;
            4'hD: segments = 7'h5E;
            4'hE: segments = 7'h79;
            default: segments = 7'h71;
         endcase
      end
   end

endmodule

// File: rtl/ssd_refresh_tick.sv
// Digit-slot prescaler: counts 0..DIV-1 and flags the last count.
//   clk     system clock
//   rst     synchronous active-high reset (count returns to 0)
//   tick_c  high while the count equals DIV-1
module ssd_refresh_tick
   import ssd_pkg::*;
#(
   parameter int unsigned DIV = SSD_DEFAULT_REFRESH_DIV
) (
   input  logic clk,
   input  logic rst,
   output logic tick_c
);

   localparam int unsigned CNT_W = ssd_idx_w(DIV);

   logic [CNT_W-1:0] cnt;

   assign tick_c = (cnt == CNT_W'(DIV - 1));

   // Free-running slot counter, wraps on the tick.
   always_ff @(posedge clk) begin
      if (rst || tick_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_ssd_multidigit.sv
// N-digit multiplexed hex display of the most recent UART bytes.
// Byte k of the shift buffer feeds digit 2k (low nibble) and 2k+1 (high
// nibble); digits whose byte has not arrived show a dash.
//   clk         system clock
//   rst         synchronous active-high reset
//   rx_data     received byte
//   rx_valid    one-cycle strobe, rx_data valid
//   clr         one-cycle strobe, forget all stored bytes
//   segments    segment drive (combinational from the registered nibble/dash)
//   dig_sel     one-hot digit enable
//   dash        active digit shows a dash
//   byte_count  number of valid bytes held, saturating at NUM_DIGITS/2
// Build option: define IDLE_TIMEOUT_EN to blank the display after
// IDLE_TIMEOUT cycles without rx_valid/clr.
module uart_ssd_multidigit
   import ssd_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = SSD_DEFAULT_REFRESH_DIV,
   parameter int unsigned IDLE_TIMEOUT = 100_000_000
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [BYTE_W-1:0]                    rx_data,
   input  logic                                 rx_valid,
   input  logic                                 clr,
   output logic [SSD_SEG_W-1:0]                 segments,
   output logic [NUM_DIGITS-1:0]                dig_sel,
   output logic                                 dash,
   output logic [ssd_clog2(NUM_DIGITS/2+1)-1:0] byte_count
);

   localparam int unsigned NUM_BYTES = NUM_DIGITS / 2;
   localparam int unsigned IDX_W     = ssd_idx_w(NUM_DIGITS);
   localparam int unsigned BSEL_W    = ssd_idx_w(NUM_BYTES);
   localparam int unsigned CNT_W     = ssd_clog2(NUM_BYTES + 1);

   if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || (NUM_DIGITS % 2) != 0) begin : g_bad_num_digits
      $error("uart_ssd_multidigit: NUM_DIGITS must be even and within 2..8");
   end
   if (IDLE_TIMEOUT < 2) begin : g_bad_idle_timeout
      $error("uart_ssd_multidigit: IDLE_TIMEOUT must be at least 2");
   end

   logic              tick_c;
   logic              drop_c;     // forget stored bytes this cycle
   logic [IDX_W-1:0]  idx;
   logic [BSEL_W-1:0] byte_sel_c;
   ssd_byte_t         byte_buf [NUM_BYTES];
   logic [3:0]        nibble;

   ssd_refresh_tick #(.DIV(REFRESH_DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .tick_c (tick_c)
   );

`ifdef IDLE_TIMEOUT_EN
   localparam int unsigned IDLE_W = ssd_idx_w(IDLE_TIMEOUT);

   logic [IDLE_W-1:0] idle_cnt;
   logic              timeout_c;

   assign timeout_c = (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));

   // Idle counter; holds at the timeout value so the blanking persists.
   always_ff @(posedge clk) begin
      if (rst || rx_valid || clr) begin
         idle_cnt <= '0;
      end else if (!timeout_c) begin
         idle_cnt <= idle_cnt + IDLE_W'(1);
      end
   end

   assign drop_c = clr | timeout_c;
`else
   assign drop_c = clr;
`endif

   // Scan index, advanced once per digit slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
      end else if (tick_c) begin
         idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end
   end

   // Byte shift buffer, newest byte in position 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_BYTES; k++) begin
            byte_buf[k] <= '0;
         end
      end else if (rx_valid) begin
         for (int k = NUM_BYTES - 1; k > 0; k--) begin
            byte_buf[k] <= byte_buf[k-1];
         end
         byte_buf[0] <= rx_data;
      end
   end

   // Valid-byte count; a drop in the same cycle as a byte leaves just that byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_count <= '0;
      end else if (rx_valid) begin
         if (drop_c) begin
            byte_count <= CNT_W'(1);
         end else if (byte_count != CNT_W'(NUM_BYTES)) begin
            byte_count <= byte_count + CNT_W'(1);
         end
      end else if (drop_c) begin
         byte_count <= '0;
      end
   end

   assign byte_sel_c = BSEL_W'(idx >> 1);

   // Registered digit outputs for the current scan position.
   always_ff @(posedge clk) begin
      if (rst) begin
         dig_sel <= NUM_DIGITS'(1);
         dash    <= 1'b1;
         nibble  <= '0;
      end else begin
         dig_sel <= NUM_DIGITS'(1) << idx;
         dash    <= (8'(idx >> 1) >= 8'(byte_count));
         nibble  <= idx[0] ? byte_buf[byte_sel_c][7:4] : byte_buf[byte_sel_c][3:0];
      end
   end

   Segment_Selector u_seg (
      .nibble   (nibble),
      .dash     (dash),
      .segments (segments)
   );

endmodule

// File: tb/tb_uart_ssd_multidigit.sv
// Self-checking bench for uart_ssd_multidigit (4 digits, 4 clk per slot).
module tb_uart_ssd_multidigit;

   localparam int unsigned N   = 4;
   localparam int unsigned DIV = 4;
   localparam int unsigned TMO = 20;
   localparam int unsigned NB  = N / 2;
   localparam logic [6:0]  SEG_DASH = 7'h40;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   rx_data;
   logic         rx_valid;
   logic         clr;
   logic [6:0]   segments;
   logic [N-1:0] dig_sel;
   logic         dash;
   logic [1:0]   byte_count;

   always #5 clk = ~clk;

   uart_ssd_multidigit #(
      .NUM_DIGITS   (N),
      .REFRESH_DIV  (DIV),
      .IDLE_TIMEOUT (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .clr        (clr),
      .segments   (segments),
      .dig_sel    (dig_sel),
      .dash       (dash),
      .byte_count (byte_count)
   );

   int errors = 0;
   int checks = 0;

   // Behavioural model: time since reset, byte history, valid count.
   logic [7:0]   m_bytes [$];
   int           m_cnt;
   int           m_t;
   int           m_cyc = 0;
   int           m_last = 0;
   bit           m_valid = 1'b0;
   logic [N-1:0] e_dig;
   logic         e_dash;
   logic [3:0]   e_nib;

   logic [6:0] hex_seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic [6:0] fr_seg  [N];
   logic       fr_dash [N];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic v, input logic [7:0] d, input logic c);
      int         idx;
      logic [7:0] b;
      bit         timeout;
      if (r) begin
         m_t = 0;
         m_bytes = {};
         for (int k = 0; k < NB; k++) m_bytes.push_back(8'h00);
         m_cnt   = 0;
         e_dig   = N'(1);
         e_dash  = 1'b1;
         e_nib   = 4'h0;
         m_valid = 1'b1;
         m_last  = m_cyc;
      end else if (m_valid) begin
         idx    = (m_t / DIV) % N;
         b      = m_bytes[idx / 2];
         e_dig  = N'(1) << idx;
         e_dash = (idx / 2) >= m_cnt;
         e_nib  = (idx % 2 == 1) ? b[7:4] : b[3:0];
         m_t++;
         timeout = 1'b0;
`ifdef IDLE_TIMEOUT_EN
         timeout = (m_cyc - m_last) >= int'(TMO);
`endif
         if (c || timeout) m_cnt = 0;
         if (v) begin
            m_bytes.push_front(d);
            void'(m_bytes.pop_back());
            if (m_cnt < NB) m_cnt++;
         end
         if (v || c) m_last = m_cyc;
      end
      m_cyc++;
   endtask

   task automatic compare();
      if (!m_valid) return;
      check("dig_sel", 32'(dig_sel), 32'(e_dig));
      check("dig_sel_onehot", 32'($onehot(dig_sel)), 32'(1));
      check("dash", 32'(dash), 32'(e_dash));
      check("byte_count", 32'(byte_count), 32'(m_cnt));
      check("segments", 32'(segments), 32'(e_dash ? SEG_DASH : hex_seg[e_nib]));
   endtask

   // One clock: drive at negedge, model at posedge, compare at next negedge.
   task automatic cycle(input logic r, input logic v, input logic [7:0] d, input logic c);
      rst = r; rx_valid = v; rx_data = d; clr = c;
      @(posedge clk);
      model_edge(r, v, d, c);
      @(negedge clk);
      compare();
   endtask

   task automatic frame();
      for (int i = 0; i < N; i++) begin
         fr_seg[i]  = 'x;
         fr_dash[i] = 1'bx;
      end
      for (int c = 0; c < N * DIV; c++) begin
         cycle(1'b0, 1'b0, 8'h00, 1'b0);
         for (int i = 0; i < N; i++) begin
            if (dig_sel[i]) begin
               fr_seg[i]  = segments;
               fr_dash[i] = dash;
            end
         end
      end
   endtask

   task automatic expect_digit(input string tag, input int i, input logic [6:0] seg, input logic dsh);
      check($sformatf("%s_dig%0d_seg", tag, i), 32'(fr_seg[i]), 32'(seg));
      check($sformatf("%s_dig%0d_dash", tag, i), 32'(fr_dash[i]), 32'(dsh));
   endtask

   initial begin
      int  n;
      bit  found;
      logic r, v, c;
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; clr = 1'b0;
      @(negedge clk);

      // Reset and idle scan
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      check("t1_reset_dig_sel", 32'(dig_sel), 32'h1);
      check("t1_reset_dash", 32'(dash), 32'h1);
      check("t1_reset_count", 32'(byte_count), 32'h0);
      for (int k = 0; k <= 16; k++) begin
         cycle(1'b0, 1'b0, 8'h00, 1'b0);
         check($sformatf("t1_scan%0d", k), 32'(dig_sel), 32'(1 << ((k / 4) % 4)));
         check($sformatf("t1_dash%0d", k), 32'(dash), 32'h1);
      end

      // One byte
      cycle(1'b0, 1'b1, 8'hA5, 1'b0);
      check("t2_count", 32'(byte_count), 32'h1);
      frame();
      expect_digit("t2", 0, 7'h6D, 1'b0);
      expect_digit("t2", 1, 7'h77, 1'b0);
      expect_digit("t2", 2, SEG_DASH, 1'b1);
      expect_digit("t2", 3, SEG_DASH, 1'b1);

      // Saturation and shift-out
      cycle(1'b0, 1'b1, 8'h12, 1'b0);
      cycle(1'b0, 1'b1, 8'h34, 1'b0);
      cycle(1'b0, 1'b1, 8'h56, 1'b0);
      check("t3_count", 32'(byte_count), 32'h2);
      frame();
      expect_digit("t3", 0, 7'h7D, 1'b0);
      expect_digit("t3", 1, 7'h6D, 1'b0);
      expect_digit("t3", 2, 7'h66, 1'b0);
      expect_digit("t3", 3, 7'h4F, 1'b0);

      // clr together with a byte
      cycle(1'b0, 1'b1, 8'h7E, 1'b1);
      check("t4_count", 32'(byte_count), 32'h1);
      frame();
      expect_digit("t4", 0, 7'h79, 1'b0);
      expect_digit("t4", 1, 7'h07, 1'b0);
      expect_digit("t4", 2, SEG_DASH, 1'b1);
      expect_digit("t4", 3, SEG_DASH, 1'b1);

      // Reset in the middle of digit 2's slot
      found = 1'b0;
      for (int k = 0; k < 2 * N * DIV && !found; k++) begin
         cycle(1'b0, 1'b0, 8'h00, 1'b0);
         if (dig_sel == 4'b0100) found = 1'b1;
      end
      check("t5_reach_digit2", 32'(found), 32'h1);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      check("t5_dig_sel", 32'(dig_sel), 32'h1);
      check("t5_dash", 32'(dash), 32'h1);
      check("t5_count", 32'(byte_count), 32'h0);
      n = 0;
      for (int k = 0; k < 3 * DIV; k++) begin
         cycle(1'b0, 1'b0, 8'h00, 1'b0);
         if (dig_sel != 4'b0001) break;
         n++;
      end
      check("t5_slot_len", 32'(n), 32'(DIV));

`ifdef IDLE_TIMEOUT_EN
      // Idle timeout, then a byte just before it expires
      cycle(1'b0, 1'b1, 8'h99, 1'b0);
      for (int k = 1; k <= 19; k++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
      check("t6_before_timeout", 32'(byte_count), 32'h1);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      check("t6_timeout", 32'(byte_count), 32'h0);
      cycle(1'b0, 1'b1, 8'h99, 1'b0);
      for (int k = 1; k <= 18; k++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b0, 1'b1, 8'h11, 1'b0);
      check("t6_rx_at_19", 32'(byte_count), 32'h2);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      check("t6_no_clear", 32'(byte_count), 32'h2);
`endif

      // Randomised traffic with occasional quiet gaps
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 99) == 0) begin
            n = int'($urandom_range(15, 30));
            for (int q = 0; q < n; q++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
         end
         r = ($urandom_range(0, 299) == 0);
         v = ($urandom_range(0, 7) == 0);
         c = ($urandom_range(0, 31) == 0);
         cycle(r, v, 8'($urandom), c);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
